ac_motor_spwm: RTL and testbench



---
 rtl/ac_motor_spwm.sv | 177 +++++++++++++++++
 tb/tb_ac_motor_spwm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ac_motor_spwm.sv
// ac_motor_spwm: three-phase sine-PWM modulator with a symmetric triangle
// carrier, a phase accumulator stepped at every carrier valley, a quarter-wave
// sine ROM with amplitude scaling, and dead-time insertion on each inverter leg.
module ac_motor_spwm #(
  parameter int resolution_bits = 12,
  parameter int phase_bits      = 24,
  parameter int pwm_bits        = 10,
  parameter int dead_time       = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [resolution_bits-1:0] FREQUENCY,
  input  logic [resolution_bits-1:0] AMPLITUDE,
  input  logic                       ENABLE,
  output logic                       U_HI,
  output logic                       U_LO,
  output logic                       V_HI,
  output logic                       V_LO,
  output logic                       W_HI,
  output logic                       W_LO,
  output logic                       SYNC
);

  localparam int SIN_W  = 10;
  localparam int S_W    = 11;
  localparam int AMP_SH = resolution_bits + 1;
  localparam int PROD_W = S_W + resolution_bits + 1;
  localparam logic [pwm_bits-1:0] CNT_MAX = '1;
  localparam logic [pwm_bits-1:0] REF_RST = pwm_bits'(1 << (pwm_bits - 1));
  localparam logic signed [PROD_W-1:0] MID_P = PROD_W'(1 << (pwm_bits - 1));
  localparam logic [7:0] DT = 8'(dead_time);
  // Leg offsets are 1/3 and 2/3 of a full turn, rounded to nearest.
  localparam logic [phase_bits-1:0] LEG_OFF [3] = '{
    '0,
    phase_bits'(((64'd1 << phase_bits) + 64'd1) / 64'd3),
    phase_bits'(((64'd2 << phase_bits) + 64'd1) / 64'd3)
  };

  // round(1023*sin(2*pi*k/1024)) evaluated at elaboration with a Q30 Taylor series
  function automatic logic [9:0] sin_q(input int k);
    longint th, x2, term, acc;
    th   = (longint'(k) * 64'sd1686629713 + 64'sd128) >>> 8;
    x2   = (th * th) >>> 30;
    term = th;
    acc  = th;
    for (int n = 1; n <= 11; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return 10'((acc * 64'sd1023 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [9:0] sin_rom [257];
  for (genvar g = 0; g < 257; g++) begin : g_sin
    localparam logic [9:0] QV = sin_q(g);
    assign sin_rom[g] = QV;
  end

  logic [pwm_bits-1:0]        cnt_q, cnt_d;
  logic                       dir_up_q, dir_up_d;
  logic                       sync_q, sync_d;
  logic [phase_bits-1:0]      phase_q, phase_d;
  logic [resolution_bits-1:0] amp_sh_q, amp_sh_d;
  logic [3:0]                 vld_q, vld_d;
  logic [SIN_W-1:0]           idx_q [3], idx_d [3];
  logic [9:0]                 mag_q [3], mag_d [3];
  logic                       neg_q [3], neg_d [3];
  logic signed [PROD_W-1:0]   prod_q [3], prod_d [3];
  logic [pwm_bits-1:0]        pend_q [3], pend_d [3];
  logic [pwm_bits-1:0]        act_q [3], act_d [3];
  logic                       r_prev_q [3], r_prev_d [3];
  logic [7:0]                 dt_q [3], dt_d [3];
  logic                       hi_q [3], hi_d [3];
  logic                       lo_q [3], lo_d [3];
  logic                       valley;

  // Next-state: carrier, valley latching, reference pipeline and dead-time gating
  always_comb begin : p_next
    logic [8:0]            k;
    logic signed [S_W-1:0] s;
    logic                  r;
    k        = '0;
    s        = '0;
    r        = 1'b0;
    valley   = (cnt_q == '0);
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    if (dir_up_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d    = CNT_MAX - 1'b1;
        dir_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == pwm_bits'(1)) dir_up_d = 1'b1;
    end
    sync_d   = valley;
    phase_d  = phase_q;
    amp_sh_d = amp_sh_q;
    act_d    = act_q;
    if (valley) begin
      phase_d  = phase_q + phase_bits'(FREQUENCY);
      amp_sh_d = AMPLITUDE;
      act_d    = pend_q;
    end
    vld_d  = {vld_q[2:0], valley};
    pend_d = pend_q;
    for (int l = 0; l < 3; l++) begin
      idx_d[l] = SIN_W'((phase_q - LEG_OFF[l]) >> (phase_bits - SIN_W));
      k = idx_q[l][8] ? (9'd256 - {1'b0, idx_q[l][7:0]}) : {1'b0, idx_q[l][7:0]};
      mag_d[l] = sin_rom[k];
      neg_d[l] = idx_q[l][9];
      s = neg_q[l] ? -$signed({1'b0, mag_q[l]}) : $signed({1'b0, mag_q[l]});
      prod_d[l] = PROD_W'(s) * PROD_W'($signed({1'b0, amp_sh_q}));
      if (vld_q[3]) pend_d[l] = pwm_bits'((prod_q[l] >>> AMP_SH) + MID_P);
      r = (act_q[l] > cnt_q);
      if (!ENABLE || (r != r_prev_q[l])) dt_d[l] = '0;
      else if (dt_q[l] >= DT)            dt_d[l] = DT;
      else                               dt_d[l] = dt_q[l] + 8'd1;
      r_prev_d[l] = r;
      hi_d[l] = r & ENABLE & (dt_d[l] >= DT);
      lo_d[l] = ~r & ENABLE & (dt_d[l] >= DT);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      sync_q   <= 1'b0;
      phase_q  <= '0;
      amp_sh_q <= '0;
      vld_q    <= '0;
      for (int l = 0; l < 3; l++) begin
        idx_q[l]    <= '0;
        mag_q[l]    <= '0;
        neg_q[l]    <= 1'b0;
        prod_q[l]   <= '0;
        pend_q[l]   <= REF_RST;
        act_q[l]    <= REF_RST;
        r_prev_q[l] <= 1'b0;
        dt_q[l]     <= '0;
        hi_q[l]     <= 1'b0;
        lo_q[l]     <= 1'b0;
      end
    end else begin
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      sync_q   <= sync_d;
      phase_q  <= phase_d;
      amp_sh_q <= amp_sh_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      r_prev_q <= r_prev_d;
      dt_q     <= dt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign U_HI = hi_q[0];
  assign U_LO = lo_q[0];
  assign V_HI = hi_q[1];
  assign V_LO = lo_q[1];
  assign W_HI = hi_q[2];
  assign W_LO = lo_q[2];
  assign SYNC = sync_q;

endmodule

// File: tb/tb_ac_motor_spwm.sv
// tb_ac_motor_spwm: cycle-by-cycle comparison of all gate outputs and SYNC
// against a behavioural model built from the carrier position, the exact sine
// function and a sliding window over raw leg state and enable history.
module tb_ac_motor_spwm;

  localparam int PERIOD = 2046;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [11:0] FREQUENCY = '0;
  logic [11:0] AMPLITUDE = '0;
  logic U_HI, U_LO, V_HI, V_LO, W_HI, W_LO, SYNC;

  ac_motor_spwm dut (
    .CLK(CLK), .RESET_N(RESET_N), .FREQUENCY(FREQUENCY), .AMPLITUDE(AMPLITUDE),
    .ENABLE(ENABLE), .U_HI(U_HI), .U_LO(U_LO), .V_HI(V_HI), .V_LO(V_LO),
    .W_HI(W_HI), .W_LO(W_LO), .SYNC(SYNC)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // single comparison point: counts and reports
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got[6:0], exp[6:0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_pos;
  int unsigned m_phase;
  int          m_amp;
  int          m_act [3];
  int          m_pend [3];
  bit          r_hist [3][9];
  bit          en_hist [8];
  bit          exp_hi [3];
  bit          exp_lo [3];
  bit          exp_sync;
  bit          started = 1'b0;
  string       tag = "reset";

  function automatic int leg_ref(input int unsigned ph, input int amp, input int leg);
    int unsigned off, p;
    int          idx, s;
    real         v;
    off = (leg == 0) ? 0 : (leg == 1) ? 5592405 : 11184811;
    p   = (ph - off) & 32'h00FF_FFFF;
    idx = int'(p >> 14);
    v   = 1023.0 * $sin(2.0 * 3.14159265358979323846 * idx / 1024.0);
    s   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return 512 + ((s * amp) >>> 13);
  endfunction

  function automatic int tri_cnt(input int pos);
    return (pos <= 1023) ? pos : PERIOD - pos;
  endfunction

  task automatic m_reset();
    m_pos = 0; m_phase = 0; m_amp = 0; exp_sync = 1'b0;
    for (int l = 0; l < 3; l++) begin
      m_act[l] = 512; m_pend[l] = 512; exp_hi[l] = 1'b0; exp_lo[l] = 1'b0;
      for (int j = 0; j < 9; j++) r_hist[l][j] = 1'b0;
    end
    for (int j = 0; j < 8; j++) en_hist[j] = 1'b0;
  endtask

  task automatic m_step(input bit rst_n, input bit en, input int f, input int a);
    int c;
    bit r, stable, en_ok;
    if (!rst_n) begin
      m_reset();
      return;
    end
    c = tri_cnt(m_pos);
    for (int j = 7; j > 0; j--) en_hist[j] = en_hist[j-1];
    en_hist[0] = en;
    en_ok = 1'b1;
    for (int j = 0; j < 8; j++) en_ok &= en_hist[j];
    for (int l = 0; l < 3; l++) begin
      r = (m_act[l] > c);
      for (int j = 8; j > 0; j--) r_hist[l][j] = r_hist[l][j-1];
      r_hist[l][0] = r;
      stable = 1'b1;
      for (int j = 0; j < 9; j++) stable &= (r_hist[l][j] == r);
      exp_hi[l] = r && en_ok && stable;
      exp_lo[l] = !r && en_ok && stable;
    end
    exp_sync = (c == 0);
    if (c == 0) begin
      m_phase = (m_phase + f) & 32'h00FF_FFFF;
      m_amp   = a;
      for (int l = 0; l < 3; l++) begin
        m_act[l]  = m_pend[l];
        m_pend[l] = leg_ref(m_phase, m_amp, l);
      end
    end
    m_pos = (m_pos + 1) % PERIOD;
  endtask

  // one clock: compare the current cycle, then drive inputs for the next edge
  task automatic cycle(input bit rst_n, input bit en, input logic [11:0] f, input logic [11:0] a);
    logic [6:0] got, exp;
    @(negedge CLK);
    if (started) begin
      got = {U_HI, U_LO, V_HI, V_LO, W_HI, W_LO, SYNC};
      exp = {exp_hi[0], exp_lo[0], exp_hi[1], exp_lo[1], exp_hi[2], exp_lo[2], exp_sync};
      chk(tag, 32'(got), 32'(exp));
    end
    RESET_N = rst_n; ENABLE = en; FREQUENCY = f; AMPLITUDE = a;
    m_step(rst_n, en, int'(f), int'(a));
    started = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] f, a;
    bit          en, found;
    m_reset();

    tag = "reset";
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 12'd1000, 12'd0);

    tag = "zero_amp";
    for (int i = 0; i < 3 * PERIOD; i++) cycle(1'b1, 1'b1, 12'd1000, 12'd0);

    tag = "static";
    cycle(1'b0, 1'b1, 12'd0, 12'd4095);
    for (int i = 0; i < 3 * PERIOD; i++) cycle(1'b1, 1'b1, 12'd0, 12'd4095);

    tag = "random";
    f = 12'($urandom); a = 12'($urandom); en = 1'b1;
    for (int i = 0; i < 20 * PERIOD; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        f = 12'($urandom);
        a = 12'($urandom);
      end
      if (en && $urandom_range(0, 1999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 39) == 0) en = 1'b1;
      cycle(1'b1, en, f, a);
    end

    tag = "midreset";
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      if (m_pos == PERIOD - 700) begin
        cycle(1'b0, 1'b1, f, a);
        found = 1'b1;
      end else begin
        cycle(1'b1, 1'b1, f, a);
      end
    end
    chk("midreset_reached", 32'(found), 32'd1);

    tag = "after_reset";
    a = 12'($urandom_range(2048, 4095));
    for (int i = 0; i < 2 * PERIOD; i++) cycle(1'b1, 1'b1, 12'd3000, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
